// File: rtl/tagged_stream_router_if.sv
// rtl/tagged_stream_router_if.sv - tagged input stream and per-output streams of the router
interface tagged_stream_router_if #(
    parameter int nbits    = 32,
    parameter int noutputs = 3
);
    localparam int addr_nbits = $clog2(noutputs);

    logic                        istream_val;
    logic                        istream_rdy;
    logic [addr_nbits+nbits-1:0] istream_msg;
    logic [0:noutputs-1]         ostream_val;
    logic [0:noutputs-1]         ostream_rdy;
    logic [noutputs*nbits-1:0]   ostream_msg;

    modport master (
        output istream_val, istream_msg, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg
    );

    modport slave (
        input  istream_val, istream_msg, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg
    );
endinterface

// File: rtl/tagged_stream_router.sv
// rtl/tagged_stream_router.sv - tag-steered demux with a 2-entry FIFO per output; ROUTER_BYPASS_EN adds same-cycle bypass
module tagged_stream_router #(
    parameter int nbits    = 32,
    parameter int noutputs = 3
) (
    input logic                   clk,
    input logic                   reset,
    tagged_stream_router_if.slave io
);
    localparam int addr_nbits = $clog2(noutputs);

    logic [addr_nbits-1:0] addr;
    logic [nbits-1:0]      data;
    logic                  in_rdy;

    logic [1:0]       count_q [noutputs];
    logic [1:0]       count_d [noutputs];
    logic             head_q  [noutputs];
    logic             head_d  [noutputs];
    logic             tail_q  [noutputs];
    logic             tail_d  [noutputs];
    logic [nbits-1:0] mem_q   [noutputs][2];

    logic [noutputs-1:0] hit;
    logic [noutputs-1:0] byp;
    logic [noutputs-1:0] enq;
    logic [noutputs-1:0] deq;

    assign addr = io.istream_msg[addr_nbits+nbits-1:nbits];
    assign data = io.istream_msg[nbits-1:0];
    assign io.istream_rdy = in_rdy;

    always_comb begin
        in_rdy         = 1'b1;
        hit            = '0;
        byp            = '0;
        enq            = '0;
        deq            = '0;
        count_d        = count_q;
        head_d         = head_q;
        tail_d         = tail_q;
        io.ostream_val = '0;
        io.ostream_msg = '0;

        // Out-of-range tags keep in_rdy=1 and match no output, so they are dropped.
        for (int i = 0; i < noutputs; i++) begin
            if (int'(addr) == i) in_rdy = (count_q[i] != 2'd2);
        end

        for (int i = 0; i < noutputs; i++) begin
            hit[i] = io.istream_val && in_rdy && (int'(addr) == i);
`ifdef ROUTER_BYPASS_EN
            byp[i] = hit[i] && (count_q[i] == 2'd0) && io.ostream_rdy[i];
`else
            byp[i] = 1'b0;
`endif
            enq[i] = hit[i] && !byp[i];
            deq[i] = (count_q[i] != 2'd0) && io.ostream_rdy[i];

            io.ostream_val[i] = (count_q[i] != 2'd0) || byp[i];
            if (count_q[i] != 2'd0)
                io.ostream_msg[(noutputs-1-i)*nbits +: nbits] = mem_q[i][head_q[i]];
            else if (byp[i])
                io.ostream_msg[(noutputs-1-i)*nbits +: nbits] = data;

            if (enq[i]) tail_d[i] = ~tail_q[i];
            if (deq[i]) head_d[i] = ~head_q[i];
            if (enq[i] && !deq[i])      count_d[i] = count_q[i] + 2'd1;
            else if (!enq[i] && deq[i]) count_d[i] = count_q[i] - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < noutputs; i++) begin
                count_q[i]  <= 2'd0;
                head_q[i]   <= 1'b0;
                tail_q[i]   <= 1'b0;
                mem_q[i][0] <= '0;
                mem_q[i][1] <= '0;
            end
        end else begin
            for (int i = 0; i < noutputs; i++) begin
                count_q[i] <= count_d[i];
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                if (enq[i]) mem_q[i][tail_q[i]] <= data;
            end
        end
    end
endmodule

// File: tb/tb_tagged_stream_router.sv
// tb/tb_tagged_stream_router.sv - directed checks of routing, back-pressure, streaming, bad tags and reset
module tb_tagged_stream_router;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    tagged_stream_router_if #(.nbits(32), .noutputs(3)) io ();

    tagged_stream_router #(.nbits(32), .noutputs(3)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slice(input int i);
        return io.ostream_msg[(2-i)*32 +: 32];
    endfunction

    task automatic test_reset();
        reset          = 1'b0;
        io.istream_val = 1'b1;
        io.istream_msg = {2'd0, 32'h1234_5678};
        io.ostream_rdy = 3'b111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL reset_val: got %b want 000", io.ostream_val); end
            checks++;
            if (io.ostream_msg !== 96'd0) begin errors++; $display("FAIL reset_msg: got %h want 0", io.ostream_msg); end
        end
        reset          = 1'b1;
        io.istream_val = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 4; a++) begin
            io.istream_msg = {2'(a), 32'h0};
            #1;
            checks++;
            if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy addr %0d: got %b want 1", a, io.istream_rdy); end
        end
    endtask

    task automatic test_single_route();
        @(negedge clk);
        io.ostream_rdy = 3'b111;
        io.istream_val = 1'b1;
        io.istream_msg = {2'd2, 32'hDEAD_BEEF};
        #1;
        checks++;
        if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL route_rdy: got %b want 1", io.istream_rdy); end
`ifdef ROUTER_BYPASS_EN
        checks++;
        if (io.ostream_val !== 3'b001 || slice(2) !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL route_bypass: val %b msg %h want 001 deadbeef", io.ostream_val, slice(2));
        end
        @(negedge clk);
        io.istream_val = 1'b0;
        #1;
`else
        checks++;
        if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL route_early: got %b want 000", io.ostream_val); end
        @(negedge clk);
        io.istream_val = 1'b0;
        #1;
        checks++;
        if (io.ostream_val !== 3'b001) begin errors++; $display("FAIL route_val: got %b want 001", io.ostream_val); end
        checks++;
        if (io.ostream_msg !== {64'd0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL route_msg: got %h want deadbeef in slice 2", io.ostream_msg); end
        @(negedge clk);
`endif
        checks++;
        if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL route_once: got %b want 000", io.ostream_val); end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        io.ostream_rdy = 3'b000;
        io.istream_val = 1'b1;
        io.istream_msg = {2'd1, 32'd1};
        #1;
        checks++;
        if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy1: got %b want 1", io.istream_rdy); end
        @(negedge clk);
        io.istream_msg = {2'd1, 32'd2};
        #1;
        checks++;
        if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy2: got %b want 1", io.istream_rdy); end
        checks++;
        if (io.ostream_val !== 3'b010 || slice(1) !== 32'd1) begin errors++; $display("FAIL bp_head1: val %b msg %h want 010 1", io.ostream_val, slice(1)); end
        @(negedge clk);
        io.istream_msg = {2'd1, 32'd3};
        #1;
        checks++;
        if (io.istream_rdy !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", io.istream_rdy); end
        io.istream_msg = {2'd0, 32'hA0};
        #1;
        checks++;
        if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL bp_other: got %b want 1", io.istream_rdy); end
        @(negedge clk);
        io.ostream_rdy = 3'b111;
        io.istream_msg = {2'd1, 32'd3};
        #1;
        checks++;
        if (io.ostream_val !== 3'b110 || slice(0) !== 32'hA0 || slice(1) !== 32'd1) begin
            errors++; $display("FAIL bp_both: val %b s0 %h s1 %h want 110 a0 1", io.ostream_val, slice(0), slice(1));
        end
        checks++;
        if (io.istream_rdy !== 1'b0) begin errors++; $display("FAIL bp_nopass: got %b want 0", io.istream_rdy); end
        @(negedge clk);
        #1;
        checks++;
        if (io.ostream_val !== 3'b010 || slice(1) !== 32'd2) begin errors++; $display("FAIL bp_head2: val %b msg %h want 010 2", io.ostream_val, slice(1)); end
        checks++;
        if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy3: got %b want 1", io.istream_rdy); end
        @(negedge clk);
        io.istream_val = 1'b0;
        #1;
        checks++;
        if (io.ostream_val !== 3'b010 || slice(1) !== 32'd3) begin errors++; $display("FAIL bp_head3: val %b msg %h want 010 3", io.ostream_val, slice(1)); end
        @(negedge clk);
        checks++;
        if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL bp_drain: got %b want 000", io.ostream_val); end
    endtask

    task automatic test_back_to_back();
        io.ostream_rdy = 3'b111;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            io.istream_val = 1'b1;
            io.istream_msg = {2'd0, 32'(k + 100)};
            #1;
            checks++;
            if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy %0d: got %b want 1", k, io.istream_rdy); end
`ifdef ROUTER_BYPASS_EN
            checks++;
            if (io.ostream_val !== 3'b100 || slice(0) !== 32'(k + 100)) begin
                errors++; $display("FAIL stream_out %0d: val %b msg %0d want 100 %0d", k, io.ostream_val, slice(0), k + 100);
            end
`else
            if (k > 0) begin
                checks++;
                if (io.ostream_val !== 3'b100 || slice(0) !== 32'(k + 99)) begin
                    errors++; $display("FAIL stream_out %0d: val %b msg %0d want 100 %0d", k, io.ostream_val, slice(0), k + 99);
                end
            end
`endif
        end
        @(negedge clk);
        io.istream_val = 1'b0;
        #1;
`ifndef ROUTER_BYPASS_EN
        checks++;
        if (io.ostream_val !== 3'b100 || slice(0) !== 32'd199) begin errors++; $display("FAIL stream_last: val %b msg %0d want 100 199", io.ostream_val, slice(0)); end
        @(negedge clk);
`endif
        checks++;
        if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL stream_idle: got %b want 000", io.ostream_val); end
    endtask

    task automatic test_bad_addr();
        @(negedge clk);
        io.ostream_rdy = 3'b111;
        io.istream_val = 1'b1;
        io.istream_msg = {2'd3, 32'h55};
        #1;
        checks++;
        if (io.istream_rdy !== 1'b1) begin errors++; $display("FAIL bad_rdy: got %b want 1", io.istream_rdy); end
        @(negedge clk);
        checks++;
        if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL bad_drop: got %b want 000", io.ostream_val); end
        io.istream_msg = {2'd1, 32'h77};
        @(negedge clk);
        io.istream_val = 1'b0;
        #1;
`ifndef ROUTER_BYPASS_EN
        checks++;
        if (io.ostream_val !== 3'b010 || slice(1) !== 32'h77) begin errors++; $display("FAIL bad_next: val %b msg %h want 010 77", io.ostream_val, slice(1)); end
        @(negedge clk);
`endif
        checks++;
        if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL bad_idle: got %b want 000", io.ostream_val); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        io.ostream_rdy = 3'b000;
        io.istream_val = 1'b1;
        io.istream_msg = {2'd0, 32'hAA};
        @(negedge clk);
        io.istream_msg = {2'd0, 32'hBB};
        @(negedge clk);
        io.istream_val = 1'b0;
        #1;
        checks++;
        if (io.ostream_val !== 3'b100 || io.istream_rdy !== 1'b0) begin
            errors++; $display("FAIL mid_full: val %b rdy %b want 100 0", io.ostream_val, io.istream_rdy);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (io.ostream_val !== 3'b000 || slice(0) !== 32'd0 || io.istream_rdy !== 1'b1) begin
            errors++; $display("FAIL mid_reset: val %b msg %h rdy %b want 000 0 1", io.ostream_val, slice(0), io.istream_rdy);
        end
        io.ostream_rdy = 3'b111;
        @(negedge clk);
        checks++;
        if (io.ostream_val !== 3'b000) begin errors++; $display("FAIL mid_gone: got %b want 000", io.ostream_val); end
        io.ostream_rdy = 3'b000;
        io.istream_val = 1'b1;
        io.istream_msg = {2'd0, 32'hCC};
        @(negedge clk);
        io.istream_val = 1'b0;
        #1;
        checks++;
        if (io.ostream_val !== 3'b100 || slice(0) !== 32'hCC) begin errors++; $display("FAIL mid_after: val %b msg %h want 100 cc", io.ostream_val, slice(0)); end
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_back_pressure();
        test_back_to_back();
        test_bad_addr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/tagged_stream_router.md
Name: tagged_stream_router

Overview:
Demultiplexer at the far end of the arbitrated link. It accepts one tagged stream (message = {addr, data}, addr in the upper bits) and steers each message to output port `addr`. Each output has a 2-entry FIFO, so a stalled output never blocks traffic bound for other outputs once its message is accepted. Sits between the link and the per-channel consumers.

Parameters:
nbits, 32, data payload width per message
noutputs, 3, number of output streams (>=2)
addr_nbits, $clog2(noutputs), localparam; width of the routing tag

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
istream_val  input  1  input message valid
istream_rdy  output  1  input ready
istream_msg  input  addr_nbits+nbits  {addr[addr_nbits-1:0], data[nbits-1:0]}
ostream_val  output  [0:noutputs-1]  per-output valid; bit i is output i
ostream_rdy  input  [0:noutputs-1]  per-output ready; bit i is output i
ostream_msg  output  noutputs*nbits  output i occupies bits [((noutputs-1-i)*nbits)+:nbits], so output 0 is the MSB slice

Behaviour:
- Transfer occurs on any stream when val=1 and rdy=1 in the same cycle.
- Decode: addr = istream_msg[addr_nbits+nbits-1:nbits]; data = low nbits.
- Per output i, a 2-entry circular FIFO holds count_i in {0,1,2}, a head pointer, and a tail pointer.
- istream_rdy is combinational from addr and the FIFO counts:
  - addr < noutputs: istream_rdy = (count_addr < 2).
  - addr >= noutputs: istream_rdy = 1; the message is accepted and discarded, and no output changes.
  - istream_rdy does not depend on istream_val or ostream_rdy.
- Enqueue to FIFO i when istream_val & istream_rdy & (addr == i); data is written at tail_i.
- ostream_val[i] = (count_i != 0). ostream_msg slice i = entry at head_i; the slice is 0 when count_i == 0.
- Dequeue from FIFO i when ostream_val[i] & ostream_rdy[i].
- Latency: one cycle minimum. A message accepted in cycle N is visible on output i in cycle N+1.
- Throughput: one message per cycle to a single output whose consumer holds rdy=1, sustained indefinitely.
- Simultaneous enqueue and dequeue on the same FIFO: count is unchanged and both pointers advance.
  - count=1: the new entry is visible in the next cycle.
  - count=2: enqueue is blocked because rdy=0. No same-cycle pass-through on full.
- Pointer wrap: pointers are 1 bit and wrap 1 -> 0. Order within each output is strictly FIFO.
- Ordering across different outputs is not guaranteed or required.
- Reset (reset==0 at a clock edge):
  - All counts and pointers become 0; FIFO storage is zeroed.
  - Next cycle: ostream_val=0 and ostream_msg=0; istream_rdy=1 for every addr.
  - Reset mid-traffic discards all buffered messages. No partial transfers survive.
- X-safety: istream_msg contents are ignored while istream_val=0 (no state change). istream_rdy may still reflect addr.

Optional Feature:
ROUTER_BYPASS_EN
- Defined: when count_i == 0 and ostream_rdy[i] == 1, an accepted message for output i is driven combinationally in the same cycle. In that cycle:
  - ostream_val[i] = 1 and ostream_msg slice i = data.
  - The message is not enqueued; latency is 0.
  - istream_rdy is unchanged (still count_addr < 2).
  - If count_i != 0, behaviour is the same as undefined.
- Undefined: no combinational input-to-output path; latency is exactly 1 cycle minimum.

Test Plan:
1. Reset hold: reset=0 for 3 cycles with istream_val=1 -> ostream_val=000 and ostream_msg=0; after release, istream_rdy=1.
2. Single route: send {addr=2, data=32'hDEADBEEF}, all ostream_rdy=1 -> next cycle ostream_val=001 and slice 2=DEADBEEF; held for one cycle only. With ROUTER_BYPASS_EN: appears in the same cycle.
3. Back-pressure: ostream_rdy[1]=0, send 3 messages to addr 1 (data 1,2,3):
   - 1 and 2 are accepted; istream_rdy=0 on the 3rd.
   - Raise ostream_rdy[1]: outputs 1,2,3 in order.
   - A message to addr 0 sent while output 1 is full is accepted.
4. Streaming: 100 back-to-back messages to addr 0 with ostream_rdy[0]=1 -> 100 consecutive outputs, no bubbles, count never exceeds 1.
5. Bad address: noutputs=3, send addr=3 data=0x55 -> istream_rdy=1 and no ostream_val asserted. A following valid message routes normally.
6. Reset mid-operation: fill output 0 (count=2), assert reset for one cycle -> ostream_val[0]=0 next cycle, and buffered data never emerges.
